// File: rtl/srl_arbiter.sv
// Four-way round-robin arbiter feeding one shared logical right shifter and one result register.
// Latency 1 cycle from grant to o_RESULT; grants stall while the result register is full and unread.
module srl_arbiter #(
  parameter int p_DATA_WIDTH = 4
) (
  input  logic                                  i_CLK,
  input  logic                                  i_RESET,
  input  logic [3:0]                            i_REQ_VALID,
  input  logic [4*p_DATA_WIDTH-1:0]             i_REQ_DATA,
  input  logic [4*($clog2(p_DATA_WIDTH)+1)-1:0] i_REQ_SHIFT,
  output logic [3:0]                            o_REQ_READY,
  output logic                                  o_RESULT_VALID,
  output logic [p_DATA_WIDTH-1:0]               o_RESULT,
  output logic [1:0]                            o_RESULT_ID,
  input  logic                                  i_RESULT_READY
);

  localparam int p_SFT_AMT_WIDTH = $clog2(p_DATA_WIDTH);
  localparam int SW = p_SFT_AMT_WIDTH + 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              ptr;
  logic [3:0]              grant;
  logic [1:0]              gnt_idx;
  logic                    found;
  logic [1:0]              idx;
  logic                    open;
  logic                    take;
  logic [p_DATA_WIDTH-1:0] operand;
  logic [SW-1:0]           shift;
  logic [p_DATA_WIDTH-1:0] shifted;

  // First valid requester at or after ptr, wrapping modulo 4.
  always_comb begin
    grant   = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && i_REQ_VALID[idx]) begin
        found        = 1'b1;
        gnt_idx      = idx;
        grant[idx]   = 1'b1;
      end
    end
  end

  assign open        = (state == EMPTY) || i_RESULT_READY;
  assign o_REQ_READY = (open && !i_RESET) ? grant : 4'b0000;
  assign take        = |o_REQ_READY;

  assign operand = i_REQ_DATA[gnt_idx*p_DATA_WIDTH +: p_DATA_WIDTH];
  assign shift   = i_REQ_SHIFT[gnt_idx*SW +: SW];
  assign shifted = (32'(shift) >= p_DATA_WIDTH) ? '0 : (operand >> shift);

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (take) state_nxt = FULL;
      FULL:    if (i_RESULT_READY && !take) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state       <= EMPTY;
      ptr         <= 2'd0;
      o_RESULT    <= '0;
      o_RESULT_ID <= 2'd0;
    end else begin
      state <= state_nxt;
      if (take) begin
        o_RESULT    <= shifted;
        o_RESULT_ID <= gnt_idx;
        ptr         <= gnt_idx + 2'd1;
      end
    end
  end

  assign o_RESULT_VALID = (state == FULL);

endmodule

// File: tb/tb_srl_arbiter.sv
// Directed bench for srl_arbiter: reset, single grant, round robin, backpressure, shift boundaries, mid-run reset.
module tb_srl_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [11:0] req_shift;
  logic [3:0]  req_ready;
  logic        result_valid;
  logic [3:0]  result;
  logic [1:0]  result_id;
  logic        result_ready;

  int vectors;
  int miscompares;

  srl_arbiter #(.p_DATA_WIDTH(4)) dut (
    .i_CLK          (clk),
    .i_RESET        (rst),
    .i_REQ_VALID    (req_valid),
    .i_REQ_DATA     (req_data),
    .i_REQ_SHIFT    (req_shift),
    .o_REQ_READY    (req_ready),
    .o_RESULT_VALID (result_valid),
    .o_RESULT       (result),
    .o_RESULT_ID    (result_id),
    .i_RESULT_READY (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [3:0] d, input logic [2:0] s);
    req_data[k*4 +: 4]  = d;
    req_shift[k*3 +: 3] = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          order [5] = '{0, 1, 2, 3, 0};
  logic [3:0]  rr_res [4] = '{4'b1000, 4'b0110, 4'b0101, 4'b0011};
  logic [2:0]  bnd_sh [4] = '{3'd0, 3'd3, 3'd4, 3'd7};
  logic [3:0]  bnd_res [4] = '{4'b1111, 4'b0001, 4'b0000, 4'b0000};

  initial begin
    vectors      = 0;
    miscompares  = 0;
    req_data     = '0;
    req_shift    = '0;
    rst          = 1'b1;
    req_valid    = 4'b1111;
    result_ready = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    step();
    chk("rst_valid", 32'(result_valid), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_id", 32'(result_id), 32'h0);

    // Single request from requester 2.
    rst       = 1'b0;
    req_valid = 4'b0100;
    set_req(2, 4'b1011, 3'd1);
    #1;
    chk("single_ready", 32'(req_ready), 32'b0100);
    step();
    chk("single_result", 32'(result), 32'b0101);
    chk("single_id", 32'(result_id), 32'd2);
    chk("single_valid", 32'(result_valid), 32'd1);

    // Drain with nothing pending: goes empty, result held.
    req_valid = 4'b0000;
    #1;
    chk("idle_ready", 32'(req_ready), 32'h0);
    step();
    chk("drain_valid", 32'(result_valid), 32'd0);
    chk("drain_hold", 32'(result), 32'b0101);
    chk("drain_hold_id", 32'(result_id), 32'd2);

    // Reset pointer, then round robin with everyone valid.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 4'b1000, 3'd0);
    set_req(1, 4'b1100, 3'd1);
    set_req(2, 4'b1011, 3'd1);
    set_req(3, 4'b1111, 3'd2);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rr_grant%0d", i), 32'(req_ready), 32'(1 << order[i]));
      step();
      chk($sformatf("rr_result%0d", i), 32'(result), 32'(rr_res[order[i]]));
      chk($sformatf("rr_id%0d", i), 32'(result_id), 32'(order[i]));
      chk($sformatf("rr_valid%0d", i), 32'(result_valid), 32'd1);
    end

    // Backpressure: full and sink stalled.
    result_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready%0d", i), 32'(req_ready), 32'h0);
      step();
      chk($sformatf("bp_result%0d", i), 32'(result), 32'b1000);
      chk($sformatf("bp_id%0d", i), 32'(result_id), 32'd0);
      chk($sformatf("bp_valid%0d", i), 32'(result_valid), 32'd1);
    end
    result_ready = 1'b1;
    req_valid    = 4'b0010;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0010);
    step();
    chk("bp_release_result", 32'(result), 32'b0110);
    chk("bp_release_id", 32'(result_id), 32'd1);
    chk("bp_release_valid", 32'(result_valid), 32'd1);

    // Shift-amount boundaries on requester 2.
    req_valid = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      set_req(2, 4'b1111, bnd_sh[i]);
      #1;
      chk($sformatf("bnd_ready%0d", i), 32'(req_ready), 32'b0100);
      step();
      chk($sformatf("bnd_result_sh%0d", bnd_sh[i]), 32'(result), 32'(bnd_res[i]));
    end

    // Grants to 0 then 1, then reset while full and a grant is otherwise possible.
    req_valid = 4'b0001;
    #1;
    chk("mid_grant0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0010;
    #1;
    chk("mid_grant1", 32'(req_ready), 32'b0010);
    step();
    chk("mid_full_id", 32'(result_id), 32'd1);
    req_valid = 4'b1111;
    rst       = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    step();
    chk("mid_rst_valid", 32'(result_valid), 32'd0);
    chk("mid_rst_result", 32'(result), 32'h0);
    chk("mid_rst_id", 32'(result_id), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'b0001);
    step();
    chk("post_rst_id", 32'(result_id), 32'd0);
    chk("post_rst_result", 32'(result), 32'b1000);
    chk("post_rst_valid", 32'(result_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
